// File: rtl/ingress_rr_arbiter.sv
// rtl/ingress_rr_arbiter.sv - packet-atomic round-robin merge of N AXI-Stream ports; optional ARB_PKT_CNT_EN adds per-port packet counters
module ingress_rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 1024,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int ID_W    = $clog2(N_PORTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        s_axis_tvalid,
  output logic [N_PORTS-1:0]        s_axis_tready,
  input  logic [N_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [N_PORTS*KEEP_W-1:0] s_axis_tkeep,
  input  logic [N_PORTS-1:0]        s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [KEEP_W-1:0]         m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  output logic                      m_axis_tfirst
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [N_PORTS*32-1:0]     pkt_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] gnt_next;
  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] last_gnt_next;
  logic [ID_W-1:0] sel;
  logic            sel_ok;
  logic            sel_last;
  logic            slot_free;
  logic            accept;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;

  // The output slot can take a new beat when it is empty or being drained this cycle.
  assign slot_free = !m_axis_tvalid || m_axis_tready;

  // Port selection: locked to the owner mid-packet, otherwise the first valid port after last_gnt.
  always_comb begin
    int idx;
    sel    = gnt;
    sel_ok = 1'b0;
    idx    = 0;
    if (state == BUSY) begin
      sel    = gnt;
      sel_ok = 1'b1;
    end else begin
      // Walk from farthest to nearest so the nearest valid port wins.
      for (int k = N_PORTS; k >= 1; k--) begin
        idx = (int'(last_gnt) + k) % N_PORTS;
        if (s_axis_tvalid[idx]) begin
          sel    = ID_W'(idx);
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign sel_last = s_axis_tlast[sel];
  assign sel_data = s_axis_tdata[int'(sel)*DATA_W +: DATA_W];
  assign sel_keep = s_axis_tkeep[int'(sel)*KEEP_W +: KEEP_W];
  assign accept   = !reset && slot_free && sel_ok && s_axis_tvalid[sel];

  // One-hot ready towards the selected port only; nothing is offered while in reset.
  always_comb begin
    s_axis_tready = '0;
    if (!reset && slot_free && sel_ok) begin
      s_axis_tready[sel] = 1'b1;
    end
  end

  // Next-state: a non-last first beat locks the port, its last beat releases it.
  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    last_gnt_next = last_gnt;
    if (accept) begin
      if (state == IDLE) begin
        last_gnt_next = sel;
        if (!sel_last) begin
          state_next = BUSY;
          gnt_next   = sel;
        end
      end else if (sel_last) begin
        state_next = IDLE;
      end
    end
  end

  // Arbitration state register; reset points last_gnt at the top port so port 0 goes first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= ID_W'(N_PORTS - 1);
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      last_gnt <= last_gnt_next;
    end
  end

  // Output register slot: loads on acceptance, holds while stalled downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tfirst <= 1'b0;
    end else if (slot_free) begin
      m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tdata  <= sel_data;
        m_axis_tkeep  <= sel_keep;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= sel;
        m_axis_tfirst <= (state == IDLE);
      end
    end
  end

`ifdef ARB_PKT_CNT_EN
  // Per-port packet counters, bumped when a port's tlast beat is accepted; wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (accept && sel_last) begin
      pkt_cnt[int'(sel)*32 +: 32] <= pkt_cnt[int'(sel)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// tb/tb_ingress_rr_arbiter.sv - self-checking bench for ingress_rr_arbiter
module tb_ingress_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*KW-1:0]   s_tkeep = '0;
  logic [N-1:0]      s_tlast = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [1:0]        m_tid;
  logic              m_tfirst;
`ifdef ARB_PKT_CNT_EN
  logic [N*32-1:0]   pkt_cnt;
`endif

  always #5 clock = ~clock;

  ingress_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .KEEP_W(KW), .ID_W(2)) dut (
    .clock(clock), .reset(reset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tfirst(m_tfirst)
`ifdef ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit       rst;
    bit [3:0] v;
    bit [3:0] tl;
    bit       mr;
    bit [3:0] sr;
    bit       mv;
    bit [1:0] tid;
    bit       tf;
    bit       tlst;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] v, bit [3:0] tl, bit mr, bit [3:0] sr,
                              bit mv, bit [1:0] tid, bit tf, bit tlst);
    vec_t x;
    x.rst = r; x.v = v; x.tl = tl; x.mr = mr; x.sr = sr;
    x.mv = mv; x.tid = tid; x.tf = tf; x.tlst = tlst;
    return x;
  endfunction

  vec_t vt[19];

  // ---------------- source queues, model, output log ----------------
  bit [31:0] qd[N][$];
  bit        ql[N][$];
  bit [31:0] exp_d[N][$];
  bit [3:0]  en = '0;
  bit        rnd = 1'b0;
  bit        mr_fix = 1'b1;
  logic [3:0] acc = '0;
  int        seq = 0;

  bit        md_v = 1'b0;
  bit [31:0] md_d = '0;
  bit [3:0]  md_k = '0;
  bit        md_l = 1'b0;
  bit        md_f = 1'b0;
  int        md_t = 0;
  int        owner = -1;
  int        ptr = N - 1;

  int        lg_tid[$];
  bit        lg_first[$];
  bit        lg_last[$];
  bit [31:0] lg_data[$];
  int        lg_cyc[$];

  task automatic load_pkt(input int p, input int len);
    bit [31:0] w;
    for (int b = 0; b < len; b++) begin
      w = {4'(p), 28'(seq)};
      seq++;
      qd[p].push_back(w);
      ql[p].push_back(b == len - 1);
      exp_d[p].push_back(w);
    end
  endtask

  task automatic clear_log();
    lg_tid.delete(); lg_first.delete(); lg_last.delete(); lg_data.delete(); lg_cyc.delete();
  endtask

  // One clock: drive sources after the edge, then at the falling edge check against the model.
  task automatic eng_cycle(input bit rst, input bit cmp_out);
    int        selp;
    bit        sf;
    bit [31:0] w;
    logic [3:0] exp_r;
    @(posedge clock); #1;
    cyc++;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
      if (qd[i].size() > 0) begin
        w = qd[i][0];
        s_tdata[i*DW +: DW] = w;
        s_tkeep[i*KW +: KW] = w[3:0];
        s_tlast[i] = ql[i][0];
      end else begin
        s_tlast[i] = 1'b0;
      end
      s_tvalid[i] = (qd[i].size() > 0) && en[i] && (!rnd || $urandom_range(3) != 0);
    end
    m_tready = rnd ? ($urandom_range(2) != 0) : mr_fix;
    @(negedge clock);
    if (m_tvalid && m_tready) begin
      lg_tid.push_back(int'(m_tid)); lg_first.push_back(m_tfirst); lg_last.push_back(m_tlast);
      lg_data.push_back(m_tdata); lg_cyc.push_back(cyc);
    end
    if (cmp_out) begin
      chk("m_tvalid", m_tvalid, md_v);
      if (md_v) begin
        chk("m_tid", m_tid, md_t);
        chk("m_tdata", m_tdata, md_d);
        chk("m_tkeep", m_tkeep, md_k);
        chk("m_tlast", m_tlast, md_l);
        chk("m_tfirst", m_tfirst, md_f);
      end
    end
    sf = !md_v || m_tready;
    selp = -1;
    if (owner >= 0) selp = owner;
    else for (int k = 1; k <= N; k++) if (selp < 0 && s_tvalid[(ptr + k) % N]) selp = (ptr + k) % N;
    exp_r = (!reset && sf && selp >= 0) ? 4'(1 << selp) : 4'h0;
    chk("s_tready", s_tready, exp_r);
    acc = s_tvalid & s_tready;
    if (reset) begin
      md_v = 1'b0; owner = -1; ptr = N - 1;
    end else if (sf) begin
      md_v = (selp >= 0) && s_tvalid[selp];
      if (md_v) begin
        md_d = s_tdata[selp*DW +: DW];
        md_k = s_tkeep[selp*KW +: KW];
        md_l = s_tlast[selp];
        md_t = selp;
        md_f = (owner < 0);
        ptr  = selp;
        owner = md_l ? -1 : selp;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      qd[i].delete(); ql[i].delete(); exp_d[i].delete();
    end
    en = '0; acc = '0; rnd = 1'b0; mr_fix = 1'b1;
    eng_cycle(1'b1, 1'b0);
    eng_cycle(1'b1, 1'b1);
    clear_log();
  endtask

  task automatic run_until(input int beats, input int budget);
    for (int c = 0; c < budget && lg_data.size() < beats; c++) eng_cycle(1'b0, 1'b1);
  endtask

  initial begin
    int total;
    int j;
    bit inp;
    int ot;

    // rst, tvalid, tlast, m_ready | s_ready, m_valid, tid, tfirst, tlast
    vt[0]  = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    vt[1]  = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    vt[2]  = mk(0, 4'hF, 4'hF, 1, 4'h1, 0, 0, 0, 0);
    vt[3]  = mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 0, 1, 1);
    vt[4]  = mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 1, 1, 1);
    vt[5]  = mk(0, 4'hF, 4'hF, 1, 4'h4, 1, 1, 1, 1);
    vt[6]  = mk(0, 4'h0, 4'hF, 1, 4'h0, 1, 2, 1, 1);
    vt[7]  = mk(0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    vt[8]  = mk(0, 4'h8, 4'h0, 1, 4'h8, 0, 0, 0, 0);
    vt[9]  = mk(0, 4'h1, 4'h0, 1, 4'h8, 1, 3, 1, 0);
    vt[10] = mk(0, 4'h9, 4'h8, 1, 4'h8, 0, 0, 0, 0);
    vt[11] = mk(0, 4'h1, 4'h1, 1, 4'h1, 1, 3, 0, 1);
    vt[12] = mk(0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 1, 1);
    vt[13] = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    vt[14] = mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    vt[15] = mk(0, 4'h2, 4'h0, 1, 4'h2, 0, 0, 0, 0);
    vt[16] = mk(1, 4'hF, 4'hF, 1, 4'h0, 1, 1, 1, 0);
    vt[17] = mk(0, 4'hF, 4'hF, 1, 4'h1, 0, 0, 0, 0);
    vt[18] = mk(0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 1, 1);

    for (int r = 0; r < 19; r++) begin
      @(posedge clock); #1;
      reset = vt[r].rst; s_tvalid = vt[r].v; s_tlast = vt[r].tl; m_tready = vt[r].mr;
      @(negedge clock);
      chk($sformatf("vec%0d s_tready", r), s_tready, vt[r].sr);
      chk($sformatf("vec%0d m_tvalid", r), m_tvalid, vt[r].mv);
      if (vt[r].mv) begin
        chk($sformatf("vec%0d m_tid", r), m_tid, vt[r].tid);
        chk($sformatf("vec%0d m_tfirst", r), m_tfirst, vt[r].tf);
        chk($sformatf("vec%0d m_tlast", r), m_tlast, vt[r].tlst);
      end
    end

    // All four ports with one 3-beat packet each: no interleave, port order 0..3.
    do_reset();
    for (int p = 0; p < N; p++) load_pkt(p, 3);
    en = 4'hF;
    run_until(12, 60);
    chk("seq3 count", lg_data.size(), 12);
    for (int k = 0; k < lg_data.size() && k < 12; k++) begin
      chk($sformatf("seq3 tid%0d", k), lg_tid[k], k / 3);
      chk($sformatf("seq3 tfirst%0d", k), lg_first[k], (k % 3) == 0);
    end

    // Port 2 owns the output; port 1 must wait through a 5-cycle valid gap.
    do_reset();
    load_pkt(2, 4);
    load_pkt(1, 2);
    en = 4'b0100;
    repeat (2) eng_cycle(1'b0, 1'b1);
    en = 4'b0010;
    repeat (5) eng_cycle(1'b0, 1'b1);
    en = 4'b0110;
    run_until(6, 40);
    chk("gap count", lg_data.size(), 6);
    for (int k = 0; k < lg_data.size() && k < 6; k++)
      chk($sformatf("gap tid%0d", k), lg_tid[k], (k < 4) ? 2 : 1);

    // Downstream stall of 4 cycles holding an 0xA5 beat.
    do_reset();
    mr_fix = 1'b0;
    qd[0].push_back(32'hA5A5_A5A5); ql[0].push_back(1'b1);
    qd[1].push_back(32'h1111_0001); ql[1].push_back(1'b1);
    en = 4'b0011;
    eng_cycle(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      eng_cycle(1'b0, 1'b1);
      chk("stall m_tvalid", m_tvalid, 1'b1);
      chk("stall m_tdata", m_tdata, 32'hA5A5_A5A5);
      chk("stall s_tready", s_tready, 4'h0);
    end
    mr_fix = 1'b1;
    run_until(2, 10);
    chk("stall count", lg_data.size(), 2);
    if (lg_data.size() >= 2) begin
      chk("stall beat0", lg_data[0], 32'hA5A5_A5A5);
      chk("stall beat1", lg_data[1], 32'h1111_0001);
    end

    // Single-beat packets on ports 1 and 3: strict alternation at one beat per cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load_pkt(1, 1);
      load_pkt(3, 1);
    end
    en = 4'b1010;
    run_until(8, 40);
    chk("alt count", lg_data.size(), 8);
    for (int k = 0; k < lg_data.size() && k < 8; k++) begin
      chk($sformatf("alt tid%0d", k), lg_tid[k], (k % 2 == 0) ? 1 : 3);
      chk($sformatf("alt first%0d", k), lg_first[k], 1'b1);
      chk($sformatf("alt last%0d", k), lg_last[k], 1'b1);
      if (k > 0) chk($sformatf("alt gap%0d", k), lg_cyc[k] - lg_cyc[k-1], 1);
    end

`ifdef ARB_PKT_CNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) load_pkt(0, 2);
    for (int k = 0; k < 2; k++) load_pkt(3, 1);
    en = 4'hF;
    run_until(12, 80);
    chk("cnt port0", pkt_cnt[0 +: 32], 32'd5);
    chk("cnt port1", pkt_cnt[32 +: 32], 32'd0);
    chk("cnt port2", pkt_cnt[64 +: 32], 32'd0);
    chk("cnt port3", pkt_cnt[96 +: 32], 32'd2);
`endif

    // Randomised traffic and back-pressure against the model.
    do_reset();
    total = 0;
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 8; k++) begin
        j = 1 + $urandom_range(3);
        load_pkt(p, j);
        total += j;
      end
    en = 4'hF;
    rnd = 1'b1;
    run_until(total, 4000);
    rnd = 1'b0;
    chk("rand count", lg_data.size(), total);
    inp = 1'b0;
    ot = 0;
    for (int k = 0; k < lg_data.size(); k++) begin
      chk("rand tfirst", lg_first[k], !inp);
      if (inp) chk("rand atomic", lg_tid[k], ot);
      ot = lg_tid[k];
      inp = !lg_last[k];
    end
    for (int p = 0; p < N; p++) begin
      j = 0;
      for (int k = 0; k < lg_data.size(); k++)
        if (lg_tid[k] == p) begin
          if (j < exp_d[p].size()) chk($sformatf("rand port%0d data", p), lg_data[k], exp_d[p][j]);
          j++;
        end
      chk($sformatf("rand port%0d beats", p), j, exp_d[p].size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
